// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register bank: ALU vs LSU on one write port,
// with a per-register pending scoreboard for decode hazard checks.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_sel_in,
    output logic [XLEN-1:0] rf_data_in
);

    localparam logic [0:0] PRIO_LSU = 1'b0;
    localparam logic [0:0] PRIO_ALU = 1'b1;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_nxt;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        alu_fire;
    logic        lsu_fire;
    logic        alu_stall;

    // Readies depend only on valids and priority, never on rd/data.
    always_comb begin
        alu_ready = 1'b1;
        lsu_ready = 1'b1;
        if (state == PRIO_LSU) begin
            alu_ready = !lsu_valid;
        end else begin
            lsu_ready = !alu_valid;
        end
    end

    assign alu_fire  = alu_valid && alu_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_stall = alu_valid && !alu_ready;

    always_comb begin
        wait_nxt = 4'd0;
        if (alu_stall) begin
            if (wait_cnt == WAIT_MAX) begin
                wait_nxt = wait_cnt;
            end else begin
                wait_nxt = wait_cnt + 4'd1;
            end
        end
    end

    // Flip to ALU priority on the edge that completes MAX_WAIT stalled cycles,
    // so the ALU is served in the very next cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            PRIO_LSU: begin
                if (wait_nxt == WAIT_MAX) begin
                    state_nxt = PRIO_ALU;
                end
            end
            PRIO_ALU: begin
                if (alu_fire || !alu_valid) begin
                    state_nxt = PRIO_LSU;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= PRIO_LSU;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Writes to x0 are accepted but never reach the bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_sel_in  <= 5'd0;
            rf_data_in <= '0;
        end else begin
            rf_we <= 1'b0;
            if (alu_fire) begin
                if (alu_rd != 5'd0) begin
                    rf_we      <= 1'b1;
                    rf_sel_in  <= alu_rd;
                    rf_data_in <= alu_data;
                end
            end else if (lsu_fire) begin
                if (lsu_rd != 5'd0) begin
                    rf_we      <= 1'b1;
                    rf_sel_in  <= lsu_rd;
                    rf_data_in <= lsu_data;
                end
            end
        end
    end

    // A new issue to the register being committed keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (rf_we) begin
            pending_nxt[rf_sel_in] = 1'b0;
        end
        if (issue_valid && issue_rd != 5'd0) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rs1_busy = pending[rs1];
    assign rs2_busy = pending[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: scoreboard of expected bank
// writes plus directed checks of arbitration, scoreboard and reset.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_sel_in;
    logic [31:0] rf_data_in;

    int errors = 0;
    int checks = 0;
    logic [36:0] expq[$];

    regfile_wb_arbiter #(.MAX_WAIT(4), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_sel_in(rf_sel_in), .rf_data_in(rf_data_in)
    );

    always #5 clock = ~clock;

    // Record accepted non-x0 transfers, then advance one clock.
    task automatic clk_cycle();
        #1;
        if (alu_valid && alu_ready && alu_rd != 5'd0)
            expq.push_back({alu_rd, alu_data});
        if (lsu_valid && lsu_ready && lsu_rd != 5'd0)
            expq.push_back({lsu_rd, lsu_data});
        @(posedge clock);
        #1;
    endtask

    function automatic logic [36:0] head();
        if (expq.size() != 0) return expq[0];
        return 'x;
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (rf_we !== 1'b0 || rf_sel_in !== 5'd0 || rf_data_in !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b sel=%0d data=%h want 0/0/0",
                     rf_we, rf_sel_in, rf_data_in);
        end
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b1 || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got alu_rdy=%b lsu_rdy=%b busy=%b want 1/1/0",
                     alu_ready, lsu_ready, rs1_busy);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_only_ready: got %b want 1", alu_ready);
        end
        clk_cycle();
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_sel_in !== 5'd5 || rf_data_in !== 32'hDEADBEEF
            || {rf_sel_in, rf_data_in} !== head()) begin
            errors++;
            $display("FAIL alu_only_write: got we=%b sel=%0d data=%h want 1/5/deadbeef",
                     rf_we, rf_sel_in, rf_data_in);
        end
        if (expq.size() != 0) void'(expq.pop_front());
        clk_cycle();
        checks++;
        if (rf_we !== 1'b0 || rf_sel_in !== 5'd5) begin
            errors++;
            $display("FAIL alu_only_idle: got we=%b sel=%0d want 0/5", rf_we, rf_sel_in);
        end
    endtask

    task automatic test_both_valid();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h22;
        #1;
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL both_ready1: got alu=%b lsu=%b want 0/1", alu_ready, lsu_ready);
        end
        clk_cycle();
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL both_ready2: got alu=%b want 1", alu_ready);
        end
        checks++;
        if (rf_we !== 1'b1 || {rf_sel_in, rf_data_in} !== {5'd7, 32'h11}
            || {rf_sel_in, rf_data_in} !== head()) begin
            errors++;
            $display("FAIL both_lsu_first: got we=%b sel=%0d data=%h want 1/7/11",
                     rf_we, rf_sel_in, rf_data_in);
        end
        if (expq.size() != 0) void'(expq.pop_front());
        clk_cycle();
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || {rf_sel_in, rf_data_in} !== {5'd8, 32'h22}
            || {rf_sel_in, rf_data_in} !== head()) begin
            errors++;
            $display("FAIL both_alu_second: got we=%b sel=%0d data=%h want 1/8/22",
                     rf_we, rf_sel_in, rf_data_in);
        end
        if (expq.size() != 0) void'(expq.pop_front());
        clk_cycle();
    endtask

    task automatic test_starvation();
        int k = 0;
        logic exp_alu;
        logic exp_lsu;
        alu_rd   = 5'd20;
        alu_data = 32'h0000A5A5;
        for (int i = 0; i < 7; i++) begin
            alu_valid = (i <= 4);
            lsu_valid = 1'b1;
            lsu_rd    = 5'(10 + k);
            lsu_data  = 32'h100 + 32'(k);
            exp_alu   = (i == 4);
            exp_lsu   = (i != 4);
            #1;
            checks++;
            if (alu_ready !== exp_alu || lsu_ready !== exp_lsu) begin
                errors++;
                $display("FAIL starve_ready[%0d]: got alu=%b lsu=%b want %b/%b",
                         i, alu_ready, lsu_ready, exp_alu, exp_lsu);
            end
            if (exp_lsu) k++;
            clk_cycle();
            checks++;
            if (rf_we !== 1'b1 || {rf_sel_in, rf_data_in} !== head()) begin
                errors++;
                $display("FAIL starve_write[%0d]: got we=%b sel=%0d data=%h want %h",
                         i, rf_we, rf_sel_in, rf_data_in, head());
            end
            if (expq.size() != 0) void'(expq.pop_front());
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        clk_cycle();
        checks++;
        if (rf_we !== 1'b0 || expq.size() != 0) begin
            errors++;
            $display("FAIL starve_drain: got we=%b left=%0d want 0/0", rf_we, expq.size());
        end
    endtask

    task automatic test_scoreboard();
        rs1 = 5'd3;
        rs2 = 5'd4;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        clk_cycle();
        issue_valid = 1'b0;
        clk_cycle();
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_set: got rs1=%b rs2=%b want 1/0", rs1_busy, rs2_busy);
        end
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        clk_cycle();
        alu_valid = 1'b0;
        checks++;
        if (rs1_busy !== 1'b1 || rf_we !== 1'b1 || {rf_sel_in, rf_data_in} !== head()) begin
            errors++;
            $display("FAIL sb_before_commit: got busy=%b we=%b sel=%0d want 1/1/3",
                     rs1_busy, rf_we, rf_sel_in);
        end
        if (expq.size() != 0) void'(expq.pop_front());
        clk_cycle();
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_after_commit: got busy=%b want 0", rs1_busy);
        end
        issue_valid = 1'b1;
        clk_cycle();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_data = 32'h34;
        clk_cycle();
        alu_valid = 1'b0;
        if (expq.size() != 0) void'(expq.pop_front());
        issue_valid = 1'b1;
        clk_cycle();
        issue_valid = 1'b0;
        checks++;
        if (rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: got busy=%b want 1", rs1_busy);
        end
        alu_valid = 1'b1; alu_data = 32'h35;
        clk_cycle();
        alu_valid = 1'b0;
        if (expq.size() != 0) void'(expq.pop_front());
        clk_cycle();
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_final_clear: got busy=%b want 0", rs1_busy);
        end
    endtask

    task automatic test_x0();
        alu_valid   = 1'b1;
        alu_rd      = 5'd0;
        alu_data    = 32'hFFFFFFFF;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b want 1", alu_ready);
        end
        clk_cycle();
        alu_valid   = 1'b0;
        issue_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || expq.size() != 0) begin
            errors++;
            $display("FAIL x0_nowrite: got we=%b busy=%b want 0/0", rf_we, rs1_busy);
        end
        clk_cycle();
        checks++;
        if (rf_we !== 1'b0 || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_idle: got we=%b busy=%b want 0/0", rf_we, rs1_busy);
        end
    endtask

    task automatic test_async_reset();
        rs1 = 5'd9;
        rs2 = 5'd12;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h77;
        lsu_valid = 1'b1; lsu_rd = 5'd1;  lsu_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            issue_valid = (i < 2);
            issue_rd    = (i == 0) ? 5'd9 : 5'd12;
            clk_cycle();
            checks++;
            if (rf_we !== 1'b1 || {rf_sel_in, rf_data_in} !== head()) begin
                errors++;
                $display("FAIL ar_lsu_write[%0d]: got we=%b sel=%0d want %h",
                         i, rf_we, rf_sel_in, head());
            end
            if (expq.size() != 0) void'(expq.pop_front());
        end
        issue_valid = 1'b0;
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0 || rs1_busy !== 1'b1
            || rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: got alu=%b lsu=%b b1=%b b2=%b want 1/0/1/1",
                     alu_ready, lsu_ready, rs1_busy, rs2_busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL ar_clear: got we=%b b1=%b b2=%b want 0/0/0",
                     rf_we, rs1_busy, rs2_busy);
        end
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_prio_lsu: got alu=%b lsu=%b want 0/1", alu_ready, lsu_ready);
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        expq.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        clk_cycle();
        checks++;
        if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL ar_after: got we=%b b1=%b b2=%b want 0/0/0",
                     rf_we, rs1_busy, rs2_busy);
        end
    endtask

    initial begin
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0;
        test_reset();
        test_alu_only();
        test_both_valid();
        test_starvation();
        test_scoreboard();
        test_x0();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register bank between two writeback sources: the ALU result path and the load/store unit (LSU) load-return path.
- Keeps a per-register pending scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register bank. Drives the bank's write-enable, write-select and write-data inputs from registers.

Parameters:
- MAX_WAIT, 4, consecutive stalled ALU cycles after which the ALU wins over the LSU (1..15).
- XLEN, 32, data width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_rd  in  5  LSU destination register
- lsu_data  in  XLEN  load data
- issue_valid  in  1  decode issues an instruction that writes a register
- issue_rd  in  5  destination of the issued instruction
- rs1  in  5  decode source query 1
- rs2  in  5  decode source query 2
- rs1_busy  out  1  rs1 has an outstanding write
- rs2_busy  out  1  rs2 has an outstanding write
- rf_we  out  1  to register bank write enable
- rf_sel_in  out  5  to register bank write select
- rf_data_in  out  XLEN  to register bank write data

Behaviour:
- Clock and reset: clock is clock; reset is reset, asynchronous, active-high.
- Reset values:
  - rf_we=0, rf_sel_in=0, rf_data_in=0.
  - Scoreboard pending[31:0]=0.
  - Wait counter=0.
  - Priority state = PRIO_LSU.
  - Reset mid-operation discards any accepted-but-unwritten request. rf_we drops immediately (asynchronous).
- Handshake:
  - A transfer occurs when valid & ready are both high at a rising edge.
  - Requesters hold rd and data stable while valid is high and ready is low.
  - Ready outputs are combinational from the valids and the priority state; there is no combinational path from data to ready.
- Priority FSM, two states:
  - PRIO_LSU (default): lsu_ready = 1. alu_ready = !lsu_valid.
  - PRIO_ALU: alu_ready = 1. lsu_ready = !alu_valid.
- Wait counter (4 bits):
  - Increments each cycle that alu_valid=1 and alu_ready=0.
  - Clears when the ALU transfers or when alu_valid=0.
  - Saturates at MAX_WAIT.
- FSM transitions:
  - PRIO_LSU -> PRIO_ALU when the counter equals MAX_WAIT at a clock edge.
  - PRIO_ALU -> PRIO_LSU after exactly one ALU transfer.
  - PRIO_ALU -> PRIO_LSU when alu_valid=0 (counter cleared).
- Write latency:
  - A transfer accepted at edge N drives rf_we=1, rf_sel_in=rd, rf_data_in=data during cycle N..N+1.
  - The bank commits at edge N+1.
  - Back-to-back transfers give one write per cycle.
  - With no transfer, rf_we=0 next cycle. rf_sel_in and rf_data_in hold their last values.
- x0 writes: a transfer with rd=0 is accepted (ready asserted normally) but produces rf_we=0.
- Scoreboard:
  - pending[issue_rd] sets at the edge where issue_valid=1, except issue_rd=0.
  - pending[rf_sel_in] clears at the edge where rf_we=1.
  - If set and clear hit the same register at the same edge, set wins.
  - pending[0] is always 0.
- Busy outputs:
  - rs1_busy = pending[rs1] and rs2_busy = pending[rs2], combinational.
  - No write-data bypass: a register reads not-busy only from the cycle after its commit edge.
- Counting: one issue maps to one writeback. Multiple outstanding writes to the same rd are not counted; the first matching writeback clears the bit. Decode must not re-issue to a busy rd.

Test Plan:
- Reset, then ALU-only: alu_rd=5, alu_data=0xDEADBEEF, one cycle -> next cycle rf_we=1, rf_sel_in=5, rf_data_in=0xDEADBEEF; following cycle rf_we=0.
- Both valid, LSU rd=7/0x11, ALU rd=8/0x22 -> LSU written first; ALU written the next cycle; alu_ready low for exactly 1 cycle.
- Starvation: lsu_valid held high with a new rd every cycle, alu_valid high, MAX_WAIT=4 -> ALU accepted on the 5th cycle; lsu_ready low that cycle; LSU resumes afterwards.
- Scoreboard: issue rd=3; rs1=3 -> rs1_busy=1 until the cycle after the rf_we=1/rf_sel_in=3 edge. Issue rd=3 on that same commit edge -> rs1_busy stays 1.
- x0: ALU transfer with rd=0, data=0xFFFFFFFF -> alu_ready=1, rf_we stays 0. issue_rd=0 -> rs1=0 never busy.
- Async reset asserted mid-cycle with rf_we=1 and pending bits set -> rf_we=0 immediately, all busy outputs 0, FSM back in PRIO_LSU.
